// File: rtl/risc_v_multi_cycle.sv
// Multi-cycle RV32I-subset core with a single shared instruction/data bus.
// Any illegal encoding or misaligned LW/SW stops the core in HALT until reset.
module risc_v_multi_cycle #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          NUM_REGS   = 32,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc_out,
  output logic                  instr_retired,
  output logic                  halted
);

  // state  | meaning
  // FETCH  | read instruction at pc into ir
  // DECODE | read rs1/rs2, build immediate, legality check
  // EXEC   | ALU / address / branch / jump target
  // MEM    | data access for LW/SW
  // WB     | register write, sequential pc advance
  // HALT   | stopped until reset
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam int RW = (NUM_REGS == 16) ? 4 : 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, a, b, imm, result, addr;
  logic [31:0] regs [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        legal, use_rs1, use_rs2, use_rd, illegal;
  logic        is_load, is_store, is_branch, is_jal, is_jalr;
  logic [31:0] imm_gen, op2, alu, ls_addr;
  logic        taken;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign f3        = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign f7        = ir[31:25];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm_gen = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OP_R: begin
        legal   = (f7 == 7'b0000000 && f3 != 3'b011) ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_I: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000 || f7 == 7'b0100000);
        else                   legal = (f3 != 3'b011);
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        imm_gen = {ir[31:12], 12'b0};
      end
      OP_LOAD: begin
        legal   = (f3 == 3'b010);
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_STORE: begin
        legal   = (f3 == 3'b010);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_BRANCH: begin
        legal   = (f3[1] == 1'b0);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OP_JAL: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OP_JALR: begin
        legal   = (f3 == 3'b000);
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // RV32E: any used register index with bit 4 set is out of range
  assign illegal = !legal || ((NUM_REGS == 16) &&
                   ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])));

  assign op2     = (opcode == OP_R) ? b : imm;
  assign ls_addr = a + imm;

  always_comb begin
    alu = a + op2;
    case (f3)
      3'b000:  alu = (opcode == OP_R && ir[30]) ? a - op2 : a + op2;
      3'b001:  alu = a << op2[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(op2)};
      3'b100:  alu = a ^ op2;
      3'b101:  alu = ir[30] ? $unsigned($signed(a) >>> op2[4:0]) : a >> op2[4:0];
      3'b110:  alu = a | op2;
      3'b111:  alu = a & op2;
      default: alu = a + op2;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = $signed(a) < $signed(b);
      3'b101:  taken = $signed(a) >= $signed(b);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (mem_ready) state_nxt = DECODE;
      DECODE: state_nxt = illegal ? HALT : EXEC;
      EXEC: begin
        if (is_load || is_store) state_nxt = (ls_addr[1:0] != 2'b00) ? HALT : MEM;
        else if (is_branch)      state_nxt = FETCH;
        else                     state_nxt = WB;
      end
      MEM:    if (mem_ready) state_nxt = is_load ? WB : FETCH;
      WB:     state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      imm    <= '0;
      result <= '0;
      addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          a   <= regs[rs1[RW-1:0]];
          b   <= regs[rs2[RW-1:0]];
          imm <= imm_gen;
        end
        EXEC: begin
          if (is_load || is_store) addr <= ls_addr;
          else if (is_branch)      pc <= taken ? pc + imm : pc + 32'd4;
          else if (is_jal || is_jalr) begin
            result <= pc + 32'd4;
            pc     <= is_jal ? pc + imm : ls_addr & ~32'd1;
          end
          else if (opcode == OP_LUI)   result <= imm;
          else if (opcode == OP_AUIPC) result <= pc + imm;
          else                         result <= alu;
        end
        MEM: begin
          if (mem_ready) begin
            if (is_load) result <= mem_rdata;
            else         pc <= pc + 32'd4;
          end
        end
        WB: begin
          if (rd != 5'd0) regs[rd[RW-1:0]] <= result;
          if (!(is_jal || is_jalr)) pc <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

  // reset gates the bus combinationally so a pending access is dropped at once
  assign mem_req       = reset && (state == FETCH || state == MEM);
  assign mem_we        = reset && (state == MEM) && is_store;
  assign mem_addr      = !reset ? '0 : (state == MEM) ? addr[ADDR_WIDTH-1:0] : pc[ADDR_WIDTH-1:0];
  assign mem_wdata     = (reset && state == MEM && is_store) ? b : 32'd0;
  assign instr_retired = reset && ((state == WB) || (state == EXEC && is_branch) ||
                                   (state == MEM && is_store && mem_ready));
  assign halted        = (state == HALT);
  assign pc_out        = pc;

endmodule

// File: tb/tb_risc_v_multi_cycle.sv
// Directed bench for risc_v_multi_cycle: word memory model with programmable
// wait states, bus access log, and hand-computed expectations.
module tb_risc_v_multi_cycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        instr_retired, halted;

  logic [31:0] mem [64];
  logic [31:0] acc_addr [64];
  logic [31:0] acc_wdata [64];
  logic        acc_we [64];
  int          acc_cyc [64];
  logic [31:0] st_addr [16];
  logic [31:0] st_data [16];
  int n_acc, n_st, n_ret, cyc, wait_left, wait_after;
  int n_checks = 0;
  int n_fail = 0;

  risc_v_multi_cycle dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .instr_retired(instr_retired), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
  end

  // memory model: decides the ready for the coming rising edge on each falling edge
  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = 1'b0;
    end else begin
      cyc++;
      if (mem_req) begin
        if (wait_left > 0) begin
          mem_ready = 1'b0;
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          if (n_acc < 64) begin
            acc_addr[n_acc]  = mem_addr;
            acc_we[n_acc]    = mem_we;
            acc_wdata[n_acc] = mem_wdata;
            acc_cyc[n_acc]   = cyc;
          end
          n_acc++;
          if (mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            if (n_st < 16) begin
              st_addr[n_st] = mem_addr;
              st_data[n_st] = mem_wdata;
            end
            n_st++;
          end else begin
            mem_rdata = mem[mem_addr[7:2]];
          end
          wait_left = wait_after;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  always @(posedge clk) if (reset && instr_retired) n_ret++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic start(input int first_wait);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0; n_acc = 0; n_st = 0; n_ret = 0;
    wait_left = first_wait;
    wait_after = 0;
    reset = 1'b1;
  endtask

  task automatic to_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 1000) check("cycle_timeout", cyc, c);
  endtask

  initial begin
    int stable, reqs;
    cyc = 0; n_acc = 0; n_st = 0; n_ret = 0; wait_left = 0; wait_after = 0;

    // reset values, then addi x1,x0,5 ; sw x1,8(x0)
    clear_mem();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_2423;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_retired", instr_retired, 0);
    check("rst_halted", halted, 0);
    check("rst_pc_out", pc_out, 0);
    start(0);
    to_cyc(1);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    to_cyc(9);
    check("sw_we", acc_we[2], 1);
    check("sw_addr", acc_addr[2], 8);
    check("sw_wdata", acc_wdata[2], 5);
    check("sw_cycle", acc_cyc[2], 8);
    check("sw_retired", n_ret, 2);

    // fetch stalled three cycles
    clear_mem();
    mem[0] = 32'h0050_0093;
    start(3);
    stable = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (mem_req === 1'b1 && mem_addr === 32'd0) stable++;
    end
    check("stall_stable", stable, 4);
    check("stall_hs_cycle", acc_cyc[0], 4);
    to_cyc(8);
    check("stall_next_fetch_cyc", acc_cyc[1], 8);
    check("stall_next_fetch_addr", acc_addr[1], 4);
    check("stall_retired", n_ret, 1);

    // beq x0,x0,+16
    clear_mem();
    mem[0] = 32'h0000_0863;
    start(0);
    to_cyc(4);
    check("beq_target", acc_addr[1], 16);
    check("beq_fetch_cyc", acc_cyc[1], 4);
    check("beq_retired", n_ret, 1);

    // addi x0,x0,7 ; sw x0,0(x0)
    clear_mem();
    mem[0] = 32'h0070_0013;
    mem[1] = 32'h0000_2023;
    start(0);
    to_cyc(8);
    check("x0_we", acc_we[2], 1);
    check("x0_addr", acc_addr[2], 0);
    check("x0_wdata", acc_wdata[2], 0);

    // ALU, load and jump mix ending on an illegal word at 44
    clear_mem();
    mem[0]  = 32'hFF80_0093;  // addi x1,x0,-8
    mem[1]  = 32'h4010_D113;  // srai x2,x1,1
    mem[2]  = 32'h0020_A1B3;  // slt  x3,x1,x2
    mem[3]  = 32'h4011_8233;  // sub  x4,x3,x1
    mem[4]  = 32'h0440_2023;  // sw   x4,64(x0)
    mem[5]  = 32'h0420_2223;  // sw   x2,68(x0)
    mem[6]  = 32'h0400_2283;  // lw   x5,64(x0)
    mem[7]  = 32'h0080_036F;  // jal  x6,+8
    mem[9]  = 32'h0062_83B3;  // add  x7,x5,x6
    mem[10] = 32'h0470_2423;  // sw   x7,72(x0)
    start(0);
    to_cyc(50);
    check("mix_store_count", n_st, 3);
    check("mix_st0_addr", st_addr[0], 64);
    check("mix_st0_data", st_data[0], 9);
    check("mix_st1_addr", st_addr[1], 68);
    check("mix_st1_data", st_data[1], 32'hFFFF_FFFC);
    check("mix_st2_addr", st_addr[2], 72);
    check("mix_st2_data", st_data[2], 41);
    check("mix_retired", n_ret, 10);
    check("mix_halted", halted, 1);
    check("mix_pc", pc_out, 44);

    // illegal all-zero word after one addi
    clear_mem();
    mem[0] = 32'h0050_0093;
    start(0);
    to_cyc(7);
    check("ill_halted", halted, 1);
    check("ill_pc", pc_out, 4);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (mem_req) reqs++;
    end
    check("ill_no_req", reqs, 0);
    check("ill_still_halted", halted, 1);
    reset = 1'b0;
    #1;
    check("ill_rst_halted", halted, 0);
    check("ill_rst_pc", pc_out, 0);

    // misaligned lw x2,2(x0)
    clear_mem();
    mem[0] = 32'h0020_2103;
    start(0);
    to_cyc(15);
    check("mis_halted", halted, 1);
    check("mis_accesses", n_acc, 1);
    check("mis_pc", pc_out, 0);

    // reset during a stalled store
    clear_mem();
    mem[0] = 32'h0010_2423;
    start(0);
    wait_after = 1000;
    to_cyc(6);
    check("stall_sw_req", mem_req, 1);
    check("stall_sw_we", mem_we, 1);
    check("stall_sw_addr", mem_addr, 8);
    reset = 1'b0;
    #1;
    check("abort_req", mem_req, 0);
    check("abort_we", mem_we, 0);
    repeat (2) @(posedge clk);
    #1;
    cyc = 0; n_acc = 0; n_st = 0; n_ret = 0;
    wait_left = 0;
    wait_after = 0;
    reset = 1'b1;
    to_cyc(1);
    check("refetch_count", n_acc, 1);
    check("refetch_addr", acc_addr[0], 0);
    check("refetch_we", acc_we[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
